// File: rtl/exu_wb_buffer.sv
// exu_wb_buffer: 2-entry elastic buffer between the ALU and writeback, with a
// register-lookup port for decode bypassing. Zero-latency path: define EXWB_BYPASS_EN.
module exu_wb_buffer #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_wen,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wen,
  output logic [WIDTH-1:0] out_pc,
  input  logic [RD_W-1:0]  lkp_rs,
  output logic             lkp_hit,
  output logic [WIDTH-1:0] lkp_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem_result [2];
  logic [RD_W-1:0]  mem_rd     [2];
  logic             mem_wen    [2];
  logic [WIDTH-1:0] mem_pc     [2];

  logic       head;
  logic       tail;
  logic [1:0] count;

  logic stored_valid;
  logic in_wen_m;
  logic bypass;
  logic enq;
  logic deq;
  logic young;
  logic rs_nz;
  logic hit_young;
  logic hit_old;

  assign stored_valid = (count != 2'd0);
  assign in_ready     = (count != 2'd2);
  assign occupancy    = count;
  // Writes to x0 are architecturally void, so they never claim a destination.
  assign in_wen_m     = in_wen & (in_rd != '0);

`ifdef EXWB_BYPASS_EN
  assign bypass = ~stored_valid & in_valid & out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign enq = in_valid & in_ready & ~bypass;
  assign deq = stored_valid & out_ready;

  always_comb begin
    out_valid  = stored_valid | bypass;
    out_result = '0;
    out_rd     = '0;
    out_wen    = 1'b0;
    out_pc     = '0;
    if (bypass) begin
      out_result = in_result;
      out_rd     = in_rd;
      out_wen    = in_wen_m;
      out_pc     = in_pc;
    end else if (stored_valid) begin
      out_result = mem_result[head];
      out_rd     = mem_rd[head];
      out_wen    = mem_wen[head];
      out_pc     = mem_pc[head];
    end
  end

  // Youngest entry sits just behind the tail; with one entry that is the head.
  assign young     = ~tail;
  assign rs_nz     = (lkp_rs != '0);
  assign hit_young = stored_valid & mem_wen[young] & (mem_rd[young] == lkp_rs);
  assign hit_old   = (count == 2'd2) & mem_wen[head] & (mem_rd[head] == lkp_rs);

  always_comb begin
    lkp_hit  = rs_nz & (hit_young | hit_old);
    lkp_data = '0;
    if (rs_nz && hit_young)
      lkp_data = mem_result[young];
    else if (rs_nz && hit_old)
      lkp_data = mem_result[head];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (enq) tail <= ~tail;
      if (deq) head <= ~head;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; every read of it is qualified by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_result[tail] <= in_result;
      mem_rd[tail]     <= in_rd;
      mem_wen[tail]    <= in_wen_m;
      mem_pc[tail]     <= in_pc;
    end
  end

endmodule
